// File: rtl/instr_encode_rv32i.sv
// RV32I instruction encoder: packs register/funct fields and a 32-bit immediate into an instruction word.
// Latency: a bundle accepted at edge N is presented on out_instr after edge N+1. Throughput is one per cycle.
// Backpressure: in_ready is combinational. It stalls only when both stages are full and out_ready is low.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   field bundle handshake (in_type, in_opcode, in_rd, in_rs1, in_rs2,
//                       in_funct3, in_funct7, in_imm)
//   out_valid/out_ready packed word handshake (out_instr, out_err)
//   instr_count         wrapping count of output handshakes
//
// Optional build macro IMM_RANGE_CHECK_EN: out_err is also raised when the immediate
// cannot be represented in its type's field. The word is still packed from the truncated bits.
module instr_encode_rv32i #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_type,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] T_I = 3'b000;
    localparam logic [2:0] T_S = 3'b001;
    localparam logic [2:0] T_B = 3'b010;
    localparam logic [2:0] T_U = 3'b011;
    localparam logic [2:0] T_J = 3'b100;
    localparam logic [2:0] T_R = 3'b101;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;   // addi x0, x0, 0

    // Stage 1: registered field bundle
    logic        s1_valid;
    logic [2:0]  s1_type;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_funct3;
    logic [6:0]  s1_funct7;
    logic [31:0] s1_imm;

    logic        s2_adv;
    logic [31:0] pack_word;
    logic        type_err;
    logic        pack_err;

    // Stage 2 is out_valid itself. It can take new data when it is empty or being drained this cycle.
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_type   <= '0;
            s1_opcode <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_funct3 <= '0;
            s1_funct7 <= '0;
            s1_imm    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_type   <= in_type;
                s1_opcode <= in_opcode;
                s1_rd     <= in_rd;
                s1_rs1    <= in_rs1;
                s1_rs2    <= in_rs2;
                s1_funct3 <= in_funct3;
                s1_funct7 <= in_funct7;
                s1_imm    <= in_imm;
            end
        end
    end

    // Immediate scatter by instruction format. Fields that a format does not use never reach the word.
    always_comb begin
        pack_word = NOP_WORD;
        type_err  = 1'b1;
        case (s1_type)
            T_I: begin
                pack_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
                type_err  = 1'b0;
            end
            T_S: begin
                pack_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
                type_err  = 1'b0;
            end
            T_B: begin
                pack_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                             s1_imm[4:1], s1_imm[11], s1_opcode};
                type_err  = 1'b0;
            end
            T_U: begin
                pack_word = {s1_imm[31:12], s1_rd, s1_opcode};
                type_err  = 1'b0;
            end
            T_J: begin
                pack_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
                type_err  = 1'b0;
            end
            T_R: begin
                pack_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
                type_err  = 1'b0;
            end
            default: begin
                pack_word = NOP_WORD;
                type_err  = 1'b1;
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // An immediate fits its field when every bit above the field's sign bit copies that sign bit.
    // B and J offsets are in half-words, so bit 0 must also be clear.
    logic imm_bad;

    always_comb begin
        imm_bad = 1'b0;
        case (s1_type)
            T_I, T_S: imm_bad = (s1_imm[31:11] != {21{s1_imm[31]}});
            T_B:      imm_bad = (s1_imm[31:12] != {20{s1_imm[31]}}) || s1_imm[0];
            T_U:      imm_bad = (s1_imm[11:0] != 12'd0);
            T_J:      imm_bad = (s1_imm[31:20] != {12{s1_imm[31]}}) || s1_imm[0];
            default:  imm_bad = 1'b0;
        endcase
    end

    assign pack_err = type_err || imm_bad;
`else
    assign pack_err = type_err;
`endif

    // Stage 2: registered packed word. It holds while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= pack_word;
                out_err   <= pack_err;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_count <= '0;
        end else if (out_valid && out_ready) begin
            instr_count <= instr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encode_rv32i.sv
// Scoreboard bench for instr_encode_rv32i: expectations are pushed when a bundle is accepted,
// and a forked monitor pops and compares them on every output handshake.
// Random bundles are checked against an arithmetic model of the RV32I immediate layouts.
module tb_instr_encode_rv32i;

    localparam int CNT_W = 16;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_type;
    logic [6:0]       in_opcode;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] instr_count;

    int total = 0;
    int bad   = 0;
    bit rand_ordy = 1'b0;
    logic [32:0] exp_q[$];

    instr_encode_rv32i #(.CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_type     (in_type),
        .in_opcode   (in_opcode),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_funct3   (in_funct3),
        .in_funct7   (in_funct7),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_err     (out_err),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Bits hi..lo of v, right-aligned.
    function automatic bit [31:0] fld(input bit [31:0] v, input int hi, input int lo);
        return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    // Reference model: returns {err, word}.
    function automatic logic [32:0] model(input logic [2:0] t, input logic [6:0] op,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] imm);
        bit [31:0] w;
        bit [31:0] regs;
        bit        e;
        int        s;
        s    = $signed(imm);
        regs = (32'(f3) << 12) | (32'(rs1) << 15);
        w    = 32'h0000_0013;
        e    = 1'b1;
        case (t)
            3'd0: begin   // I
                w = 32'(op) | (32'(rd) << 7) | regs | (fld(imm, 11, 0) << 20);
                e = RC && (s < -2048 || s > 2047);
            end
            3'd1: begin   // S
                w = 32'(op) | (fld(imm, 4, 0) << 7) | regs | (32'(rs2) << 20) | (fld(imm, 11, 5) << 25);
                e = RC && (s < -2048 || s > 2047);
            end
            3'd2: begin   // B
                w = 32'(op) | (fld(imm, 11, 11) << 7) | (fld(imm, 4, 1) << 8) | regs
                    | (32'(rs2) << 20) | (fld(imm, 10, 5) << 25) | (fld(imm, 12, 12) << 31);
                e = RC && (s < -4096 || s > 4095 || (s % 2) != 0);
            end
            3'd3: begin   // U
                w = 32'(op) | (32'(rd) << 7) | (fld(imm, 31, 12) << 12);
                e = RC && ((imm % 32'd4096) != 32'd0);
            end
            3'd4: begin   // J
                w = 32'(op) | (32'(rd) << 7) | (fld(imm, 19, 12) << 12) | (fld(imm, 11, 11) << 20)
                    | (fld(imm, 10, 1) << 21) | (fld(imm, 20, 20) << 31);
                e = RC && (s < -1048576 || s > 1048575 || (s % 2) != 0);
            end
            3'd5: begin   // R
                w = 32'(op) | (32'(rd) << 7) | regs | (32'(rs2) << 20) | (32'(f7) << 25);
                e = 1'b0;
            end
            default: begin
                w = 32'h0000_0013;
                e = 1'b1;
            end
        endcase
        return {e, w};
    endfunction

    task automatic set_fields(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
        in_type   = t;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    // Present one bundle until it is accepted. The expectation is queued at the accepting cycle.
    task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic [32:0] exp);
        bit acc = 1'b0;
        set_fields(t, op, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (rand_ordy) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            if (in_ready) begin
                exp_q.push_back(exp);
                acc = 1'b1;
            end
            @(posedge clock);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_rand();
        logic [2:0]  t;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        t   = 3'($urandom_range(0, 7));
        op  = 7'($urandom);
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        f3  = 3'($urandom);
        f7  = 7'($urandom);
        case ($urandom_range(0, 3))
            0:       imm = $urandom;
            1:       imm = 32'($signed($urandom_range(0, 8191)) - 4096);
            2:       imm = $urandom & 32'hFFFF_F000;
            default: imm = 32'($signed($urandom_range(0, 2097151)) - 1048576);
        endcase
        send(t, op, rd, rs1, rs2, f3, f7, imm, model(t, op, rd, rs1, rs2, f3, f7, imm));
    endtask

    task automatic drain();
        rand_ordy = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clock);
            #1;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic monitor_loop();
        logic [CNT_W-1:0] mcnt = '0;
        logic [31:0]      prev_instr = '0;
        logic             prev_err = 1'b0;
        bit               prev_stall = 1'b0;
        logic [32:0]      e;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
                mcnt       = '0;
                prev_stall = 1'b0;
            end else begin
                check("instr_count", 32'(instr_count), 32'(mcnt));
                if (prev_stall) begin
                    check("hold_instr", out_instr, prev_instr);
                    check("hold_err", 32'(out_err), 32'(prev_err));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_instr", out_instr, e[31:0]);
                        check("out_err", 32'(out_err), 32'(e[32]));
                    end
                    mcnt = mcnt + 1'b1;
                end
                prev_stall = out_valid && !out_ready;
                prev_instr = out_instr;
                prev_err   = out_err;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

        fork
            monitor_loop();
            begin
                #2_000_000;
                $display("FAIL watchdog: got timeout, want completion");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        out_ready = 1'b1;

        // Directed words with hand-computed expectations.
        send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h7F, 32'd5, {1'b0, 32'h0050_0093});
        check("lat_edge_n", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;
        check("lat_edge_n1", 32'(out_valid), 32'd1);
        send(3'd1, 7'h23, 5'd31, 5'd1, 5'd2, 3'd2, 7'h7F, 32'd8, {1'b0, 32'h0020_A423});
        send(3'd2, 7'h63, 5'd31, 5'd0, 5'd0, 3'd0, 7'h7F, 32'hFFFF_FFFC, {1'b0, 32'hFE00_0EE3});
        send(3'd3, 7'h37, 5'd5, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h1234_5000, {1'b0, 32'h1234_52B7});
        send(3'd4, 7'h6F, 5'd1, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h0000_0800, {1'b0, 32'h0010_00EF});
        send(3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, {1'b0, 32'h4020_81B3});
        send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048, {RC, 32'h8000_0093});
        send(3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFF_FFFF, {1'b1, 32'h0000_0013});
        send(3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, {1'b1, 32'h0000_0013});
        send(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, {RC, 32'h0000_0263});
        send(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, {RC, 32'h1234_52B7});
        drain();

        // Backpressure: two bundles fill the pipe, the third must wait, then all three drain back to back.
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        out_ready = 1'b0;
        send(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'd1, {1'b0, 32'h0011_0093});
        send(3'd0, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'h00, 32'd2, {1'b0, 32'h0021_0113});
        set_fields(3'd0, 7'h13, 5'd3, 5'd2, 5'd0, 3'd0, 7'h00, 32'd3);
        in_valid = 1'b1;
        @(negedge clock);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        if (in_ready) exp_q.push_back({1'b0, 32'h0031_0193});
        check("bp_consec0", 32'(out_valid), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k < 3; k++) begin
            @(negedge clock);
            check("bp_consec", 32'(out_valid), 32'd1);
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        check("bp_count", 32'(instr_count), 32'd3);
        check("bp_empty", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;
        drain();

        // Randomised traffic with random downstream stalls and idle gaps.
        rand_ordy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            send_rand();
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clock);
                #1;
            end
        end
        drain();

        // Reset with two bundles in flight: they must vanish immediately and never emerge.
        out_ready = 1'b0;
        send_rand();
        send_rand();
        #2;
        reset = 1'b1;
        #1;
        check("rst_fly_valid", 32'(out_valid), 32'd0);
        check("rst_fly_count", 32'(instr_count), 32'd0);
        check("rst_fly_err", 32'(out_err), 32'd0);
        check("rst_fly_instr", out_instr, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_count", 32'(instr_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
